hazard_ctrl: RTL
================

# hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, and the EX-stage operand forwarding muxes. It holds a multi-cycle multiply/divide (MDU) instruction in EX for `MDU_LAT` cycles. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `MDU_LAT`, default 4: total cycles an MDU instruction occupies EX; legal range 2..255.
- `CNTW`, default 32: width of the stall performance counter.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `rs_d5`, `rt_d5`  in  5  decode-stage source registers.
- `rs_e5`, `rt_e5`  in  5  execute-stage source registers.
- `write_reg_e5`, `write_reg_m5`, `write_reg_w5`  in  5  destination register in E/M/W.
- `enable_wreg_e`, `enable_wreg_m`, `enable_wreg_w`  in  1  register-write enable in E/M/W.
- `mem_to_reg_e`  in  1  EX instruction is a load.
- `pc_src_e`  in  1  taken branch or jump resolved in EX.
- `mdu_start_e`  in  1  EX instruction is an MDU op; held while the op sits in EX.
- `perf_clr_i`  in  1  synchronous clear of `stall_cnt_o`.
- `stall_f`, `stall_d`, `stall_e`  out  1  hold the PC, IF/ID and ID/EX registers.
- `flush_d`, `flush_e`, `flush_m`  out  1  load a bubble into IF/ID, ID/EX and EX/MEM.
- `fwd_a_e2`, `fwd_b_e2`  out  2  operand source: 00 = register file, 10 = MEM ALU result, 01 = WB result.
- `mdu_busy_o`  out  1  FSM is in state MDU.
- `mdu_done_o`  out  1  final EX cycle of an MDU op.
- `stall_cnt_o`  out  CNTW  count of cycles with `stall_d`=1.

## Operation
- FSM states are RUN and MDU, with a down-counter `cnt` of 8 bits.
- RUN with `mdu_start_e`=1 and `pc_src_e`=0:
  - `stall_f`/`stall_d`/`stall_e`=1 and `flush_m`=1.
  - `cnt` loads `MDU_LAT`-2.
  - Next state is MDU.
- MDU with `cnt`≠0:
  - `stall_f`/`stall_d`/`stall_e`=1 and `flush_m`=1.
  - `cnt` decrements.
  - `pc_src_e`, load-use and `mdu_start_e` are ignored.
- MDU with `cnt`=0:
  - No MDU stall; `mdu_done_o`=1.
  - Next state is RUN.
  - Normal hazard logic applies this cycle.
- Load-use stall condition: `mem_to_reg_e` & `enable_wreg_e` & (`write_reg_e5`≠0) & (`write_reg_e5`==`rs_d5` | `write_reg_e5`==`rt_d5`).
  - Response: `stall_f`=`stall_d`=1 and `flush_e`=1.
- Taken branch (`pc_src_e`=1): `flush_d`=`flush_e`=1, no stalls.
- Priority: MDU stall > `pc_src_e` > load-use. If `pc_src_e` and `mdu_start_e` are both asserted in RUN, the branch wins and the FSM stays in RUN.
- `flush_e` and `flush_d` are never asserted while `stall_e`=1.
- Forwarding for A (B is identical, using `rt_e5`):
  - 10 if `enable_wreg_m` & `write_reg_m5`≠0 & `write_reg_m5`==`rs_e5`.
  - Otherwise 01 if `enable_wreg_w` & `write_reg_w5`≠0 & `write_reg_w5`==`rs_e5`.
  - Otherwise 00.
  - MEM has priority over WB. Register 0 is never forwarded.
- `stall_cnt_o` increments each cycle `stall_d`=1 and saturates at all-ones.
  - `perf_clr_i` clears it to 0 and takes precedence over an increment in the same cycle.

## Timing
- Stall, flush, forward and `mdu_done_o` outputs are combinational from inputs and state, valid in the same cycle. `mdu_busy_o` and `stall_cnt_o` are registered.
- An MDU instruction occupies EX for exactly `MDU_LAT` cycles:
  - `MDU_LAT`-1 stalled cycles, then one release cycle.
  - The next instruction enters EX on the following edge.
- Reset values: state RUN, `cnt`=0, `stall_cnt_o`=0, `mdu_busy_o`=0.
  - All stall/flush outputs, `mdu_done_o` and `fwd_*` are forced to 0 while `reset_i`=1.
  - Reset asserted mid-MDU aborts the sequence immediately; the MDU op is lost.
- `MDU_LAT`=2: one stalled cycle, then the release cycle; the FSM visits MDU with `cnt`=0.
- Back-to-back MDU ops: `mdu_start_e` in the RUN cycle after a release starts a new sequence with no gap.

## Test plan
- Load-use: E = lw to r5, `rs_d5`=5 → exactly 1 cycle of `stall_f`=`stall_d`=`flush_e`=1. Same with `write_reg_e5`=0 → no stall.
- Forwarding: M and W both write r3, `rs_e5`=3 → `fwd_a_e2`=10. Only W writes r3 → 01. `rt_e5`=0 with M writing r0 → `fwd_b_e2`=00.
- MDU, `MDU_LAT`=4: `mdu_start_e` held → `stall_e`=1 for 3 cycles, then `mdu_done_o`=1 for 1 cycle; `mdu_busy_o`=1 for cycles 2–4; `stall_cnt_o` advances by 3.
- Priority: `pc_src_e`=1 with `mdu_start_e`=1 in RUN → `flush_d`=`flush_e`=1, no stall, FSM stays in RUN. `pc_src_e`=1 pulsed during MDU → ignored.
- Reset mid-MDU at stalled cycle 2 → all outputs 0 immediately; after release, `mdu_start_e`=0 → normal RUN behaviour.
- Counter: force `stall_cnt_o` near max (`CNTW`=4) → saturates at 15. `perf_clr_i` asserted together with a stall → next value 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl
//   Stall/flush/forwarding controller for the 5-stage pipeline, with an
//   MDU hold sequencer and a saturating stall-cycle counter.
// Revision: 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNTW    = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [4:0]      rs_d5,
    input  logic [4:0]      rt_d5,
    input  logic [4:0]      rs_e5,
    input  logic [4:0]      rt_e5,
    input  logic [4:0]      write_reg_e5,
    input  logic [4:0]      write_reg_m5,
    input  logic [4:0]      write_reg_w5,
    input  logic            enable_wreg_e,
    input  logic            enable_wreg_m,
    input  logic            enable_wreg_w,
    input  logic            mem_to_reg_e,
    input  logic            pc_src_e,
    input  logic            mdu_start_e,
    input  logic            perf_clr_i,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            flush_d,
    output logic            flush_e,
    output logic            flush_m,
    output logic [1:0]      fwd_a_e2,
    output logic [1:0]      fwd_b_e2,
    output logic            mdu_busy_o,
    output logic            mdu_done_o,
    output logic [CNTW-1:0] stall_cnt_o
);

    typedef enum logic [0:0] {
        RUN = 1'b0,
        MDU = 1'b1
    } state_t;

    // The launch cycle is spent in RUN and the release cycle at cnt==0,
    // so the down-counter covers the remaining MDU_LAT-2 stalled cycles.
    localparam logic [7:0]      CNT_INIT = 8'(MDU_LAT - 2);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       mdu_stall;
    logic       load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       en_m,
        input logic [4:0] wr_m,
        input logic       en_w,
        input logic [4:0] wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (en_m && (wr_m != 5'd0) && (wr_m == src)) begin
            sel = 2'b10;
        end else if (en_w && (wr_w != 5'd0) && (wr_w == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mdu_stall  = 1'b0;
        mdu_done_o = 1'b0;
        case (state)
            RUN: begin
                // A simultaneous taken branch squashes the MDU op instead.
                if (mdu_start_e && !pc_src_e) begin
                    mdu_stall = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = MDU;
                end
            end
            MDU: begin
                if (cnt != 8'd0) begin
                    mdu_stall = 1'b1;
                    cnt_nxt   = cnt - 8'd1;
                end else begin
                    mdu_done_o = 1'b1;
                    state_nxt  = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 8'd0;
            end
        endcase
        if (reset_i) begin
            mdu_stall  = 1'b0;
            mdu_done_o = 1'b0;
        end
    end

    assign load_use = mem_to_reg_e && enable_wreg_e && (write_reg_e5 != 5'd0) &&
                      ((write_reg_e5 == rs_d5) || (write_reg_e5 == rt_d5));

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        fwd_a_e2 = 2'b00;
        fwd_b_e2 = 2'b00;
        if (!reset_i) begin
            fwd_a_e2 = fwd_sel(rs_e5, enable_wreg_m, write_reg_m5, enable_wreg_w, write_reg_w5);
            fwd_b_e2 = fwd_sel(rt_e5, enable_wreg_m, write_reg_m5, enable_wreg_w, write_reg_w5);
            if (mdu_stall) begin
                // EX holds the MDU op; MEM receives bubbles meanwhile.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign mdu_busy_o = (state == MDU);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_o <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_o <= '0;
        end else if (stall_d && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_ONE;
        end
    end

endmodule
`default_nettype wire
